// File: rtl/decode_stage.sv
// decode_stage: registered instruction-decode stage between fetch and execute.
// The stage accepts instr/pcPlus4 over a valid/ready handshake. One cycle later
// it presents a decoded control bundle from a single output register.
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   flush               kill the held bundle and block input this cycle
//   inValid/inReady     fetch-side handshake; instr (32b), pcPlus4 (XLEN)
//   outValid/outReady   execute-side handshake
//   rs, rt, rd, regWAddr, op, pcSrcCtrl, regDInCtrl, regWe, dmWe, bneCtrl,
//   aluBSrcCtrl, imm, jAddr, pcPlus4Out, illegal   registered decoded bundle
//   stall               combinational load-use interlock
module decode_stage #(
  parameter int XLEN           = 32,
  parameter bit ENABLE_EXT     = 1'b1,
  parameter bit ZERO_EXT_LOGIC = 1'b1,
  parameter int LINK_REG       = 31
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            inValid,
  output logic            inReady,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pcPlus4,
  output logic            outValid,
  input  logic            outReady,
  output logic [4:0]      rs,
  output logic [4:0]      rt,
  output logic [4:0]      rd,
  output logic [4:0]      regWAddr,
  output logic [2:0]      op,
  output logic [1:0]      pcSrcCtrl,
  output logic [1:0]      regDInCtrl,
  output logic            regWe,
  output logic            dmWe,
  output logic            bneCtrl,
  output logic            aluBSrcCtrl,
  output logic [XLEN-1:0] imm,
  output logic [25:0]     jAddr,
  output logic [XLEN-1:0] pcPlus4Out,
  output logic            illegal,
  output logic            stall
);

  localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_XOR = 3'd2, OP_SLT = 3'd3;
  localparam logic [2:0] OP_AND = 3'd4, OP_NOR = 3'd6, OP_OR = 3'd7;
  localparam logic [1:0] PC_J = 2'd1, PC_JR = 2'd2, PC_BR = 2'd3;
  localparam logic [1:0] RD_DM = 2'd1, RD_LINK = 2'd2;
  localparam logic [4:0] LINK_ADDR = 5'(LINK_REG);

  logic [5:0] opcode, funct;
  logic [4:0] in_rs, in_rt, in_rd;
  assign opcode = instr[31:26];
  assign funct  = instr[5:0];
  assign in_rs  = instr[25:21];
  assign in_rt  = instr[20:16];
  assign in_rd  = instr[15:11];

  // Decoded bundle for the incoming instruction
  logic [2:0] op_next;
  logic [1:0] pcsrc_next, regdin_next;
  logic       regwe_next, dmwe_next, bne_next, alub_next, illegal_next;
  logic [4:0] waddr_next;
  logic [XLEN-1:0] imm_next, imm_sext, imm_zext;

  generate
    if (XLEN > 16) begin : g_imm_wide
      assign imm_sext = {{(XLEN-16){instr[15]}}, instr[15:0]};
      assign imm_zext = {{(XLEN-16){1'b0}}, instr[15:0]};
    end else begin : g_imm_narrow
      assign imm_sext = instr[15:0];
      assign imm_zext = instr[15:0];
    end
  endgenerate

  // Only the logical immediates (ANDI/ORI/XORI) may be zero-extended.
  assign imm_next = (ZERO_EXT_LOGIC && (opcode == 6'h0c || opcode == 6'h0d || opcode == 6'h0e))
                    ? imm_zext : imm_sext;

  always_comb begin
    op_next      = OP_ADD;
    pcsrc_next   = 2'd0;
    regdin_next  = 2'd0;
    regwe_next   = 1'b0;
    dmwe_next    = 1'b0;
    bne_next     = 1'b0;
    alub_next    = 1'b0;
    waddr_next   = 5'd0;
    illegal_next = 1'b0;
    case (opcode)
      6'h23: begin alub_next = 1'b1; regwe_next = 1'b1; regdin_next = RD_DM; waddr_next = in_rt; end
      6'h2b: begin alub_next = 1'b1; dmwe_next = 1'b1; end
      6'h02: pcsrc_next = PC_J;
      6'h03: begin pcsrc_next = PC_J; regwe_next = 1'b1; regdin_next = RD_LINK; waddr_next = LINK_ADDR; end
      6'h04, 6'h05: begin op_next = OP_SUB; pcsrc_next = PC_BR; bne_next = opcode[0]; end
      6'h08: begin alub_next = 1'b1; regwe_next = 1'b1; waddr_next = in_rt; end
      6'h0e: begin op_next = OP_XOR; alub_next = 1'b1; regwe_next = 1'b1; waddr_next = in_rt; end
      6'h0a, 6'h0c, 6'h0d: begin
        alub_next  = 1'b1;
        regwe_next = 1'b1;
        waddr_next = in_rt;
        op_next    = (opcode == 6'h0a) ? OP_SLT : (opcode == 6'h0c) ? OP_AND : OP_OR;
        illegal_next = !ENABLE_EXT;
      end
      6'h00: begin
        waddr_next = in_rd;
        case (funct)
          6'h08: pcsrc_next = PC_JR;
          6'h20: regwe_next = 1'b1;
          6'h22: begin op_next = OP_SUB; regwe_next = 1'b1; end
          6'h2a: begin op_next = OP_SLT; regwe_next = 1'b1; end
          6'h24: begin op_next = OP_AND; regwe_next = 1'b1; illegal_next = !ENABLE_EXT; end
          6'h25: begin op_next = OP_OR;  regwe_next = 1'b1; illegal_next = !ENABLE_EXT; end
          6'h26: begin op_next = OP_XOR; regwe_next = 1'b1; illegal_next = !ENABLE_EXT; end
          6'h27: begin op_next = OP_NOR; regwe_next = 1'b1; illegal_next = !ENABLE_EXT; end
          6'h09: begin
            pcsrc_next = PC_JR; regdin_next = RD_LINK; regwe_next = 1'b1;
            illegal_next = !ENABLE_EXT;
          end
          default: illegal_next = 1'b1;
        endcase
      end
      default: illegal_next = 1'b1;
    endcase
    // An illegal instruction travels down the pipe as a harmless NOP-like bundle.
    if (illegal_next) begin
      op_next     = OP_ADD;
      pcsrc_next  = 2'd0;
      regdin_next = 2'd0;
      regwe_next  = 1'b0;
      dmwe_next   = 1'b0;
      bne_next    = 1'b0;
      alub_next   = 1'b0;
      waddr_next  = 5'd0;
    end
    // $zero is never written.
    if (waddr_next == 5'd0) regwe_next = 1'b0;
  end

  // Output register
  logic            valid_reg, regwe_reg, dmwe_reg, bne_reg, alub_reg, illegal_reg;
  logic [4:0]      rs_reg, rt_reg, rd_reg, waddr_reg;
  logic [2:0]      op_reg;
  logic [1:0]      pcsrc_reg, regdin_reg;
  logic [XLEN-1:0] imm_reg, pc_reg;
  logic [25:0]     jaddr_reg;

  // Load-use hazard: the held bundle is a load whose destination the incoming
  // instruction reads. J/JAL read no register; only R-type, branches and SW read rt.
  logic reads_rs, reads_rt, accept;
  assign reads_rs = (opcode != 6'h02) && (opcode != 6'h03);
  assign reads_rt = (opcode == 6'h00) || (opcode == 6'h04) || (opcode == 6'h05) || (opcode == 6'h2b);
  assign stall = inValid && valid_reg && (regdin_reg == RD_DM) && regwe_reg &&
                 ((reads_rs && in_rs == waddr_reg) || (reads_rt && in_rt == waddr_reg));
  assign inReady = !reset && (!valid_reg || outReady) && !stall && !flush;
  assign accept  = inValid && inReady;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_reg   <= 1'b0;
      rs_reg      <= '0;
      rt_reg      <= '0;
      rd_reg      <= '0;
      waddr_reg   <= '0;
      op_reg      <= OP_ADD;
      pcsrc_reg   <= '0;
      regdin_reg  <= '0;
      regwe_reg   <= 1'b0;
      dmwe_reg    <= 1'b0;
      bne_reg     <= 1'b0;
      alub_reg    <= 1'b0;
      illegal_reg <= 1'b0;
      imm_reg     <= '0;
      jaddr_reg   <= '0;
      pc_reg      <= '0;
    end else if (flush) begin
      valid_reg <= 1'b0;
    end else if (accept) begin
      valid_reg   <= 1'b1;
      rs_reg      <= in_rs;
      rt_reg      <= in_rt;
      rd_reg      <= in_rd;
      waddr_reg   <= waddr_next;
      op_reg      <= op_next;
      pcsrc_reg   <= pcsrc_next;
      regdin_reg  <= regdin_next;
      regwe_reg   <= regwe_next;
      dmwe_reg    <= dmwe_next;
      bne_reg     <= bne_next;
      alub_reg    <= alub_next;
      illegal_reg <= illegal_next;
      imm_reg     <= imm_next;
      jaddr_reg   <= instr[25:0];
      pc_reg      <= pcPlus4;
    end else if (outReady) begin
      valid_reg <= 1'b0;
    end
  end

  assign outValid    = valid_reg;
  assign rs          = rs_reg;
  assign rt          = rt_reg;
  assign rd          = rd_reg;
  assign regWAddr    = waddr_reg;
  assign op          = op_reg;
  assign pcSrcCtrl   = pcsrc_reg;
  assign regDInCtrl  = regdin_reg;
  assign regWe       = regwe_reg;
  assign dmWe        = dmwe_reg;
  assign bneCtrl     = bne_reg;
  assign aluBSrcCtrl = alub_reg;
  assign imm         = imm_reg;
  assign jAddr       = jaddr_reg;
  assign pcPlus4Out  = pc_reg;
  assign illegal     = illegal_reg;

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
Registered, parametrised instruction-decode pipeline stage for the MIPS-subset core. It sits between fetch and execute. It accepts an instruction and its PC+4 over a valid/ready handshake, then presents a fully decoded control bundle one cycle later. Compared with the combinational decoder, it adds:
- an extended opcode set;
- selectable immediate extension;
- a load-use interlock that inserts bubbles;
- a branch flush;
- an illegal-instruction flag.

Parameters:
XLEN, 32, datapath width; imm and pcPlus4 width; legal range ≥16.
ENABLE_EXT, 1, 1 = decode ANDI/ORI/SLTI and R-type AND/OR/XOR/NOR/JALR; 0 = those encodings are illegal.
ZERO_EXT_LOGIC, 1, 1 = ANDI/ORI/XORI immediates zero-extended; 0 = sign-extended.
LINK_REG, 31, destination register for JAL.

Ports:
clk  in  1  clock; all state updates on rising edge.
reset  in  1  synchronous, active-high reset.
flush  in  1  kill held instruction (taken branch/jump in execute).
inValid  in  1  fetch presents instr/pcPlus4.
inReady  out  1  stage accepts input this cycle.
instr  in  32  instruction word.
pcPlus4  in  XLEN  PC+4 of instr.
outValid  out  1  decoded bundle valid.
outReady  in  1  execute consumes bundle this cycle.
rs, rt, rd  out  5 each  register fields.
regWAddr  out  5  writeback register.
op  out  3  ALU op: ADD0 SUB1 XOR2 SLT3 AND4 NAND5 NOR6 OR7.
pcSrcCtrl  out  2  INC4=0, J=1, JR=2, BR=3.
regDInCtrl  out  2  ALU=0, DM=1, LINK=2.
regWe, dmWe, bneCtrl, aluBSrcCtrl  out  1 each  control strobes; aluBSrcCtrl REG=0, IMM=1.
imm  out  XLEN  extended instr[15:0].
jAddr  out  26  instr[25:0].
pcPlus4Out  out  XLEN  registered pcPlus4.
illegal  out  1  unrecognised opcode/funct.
stall  out  1  load-use interlock active (combinational).

Behaviour:

Reset:
- outValid=0.
- All registered outputs are 0: op=ADD, pcSrcCtrl=INC4, regDInCtrl=ALU, strobes 0, illegal=0.

Storage and handshake:
- Single output register, latency 1 cycle from accept to outValid.
- Accept occurs when inValid && inReady.
- inReady = (!outValid || outReady) && !stall && !flush.
- On accept: load decoded bundle; outValid=1 next cycle.
- If outValid && outReady and no accept: outValid=0 next cycle.
- If not outReady: the bundle holds stable.

Load-use stall:
- stall = outValid && held regDInCtrl==DM && held regWe && (incoming reads rs && rs==held regWAddr, or incoming reads rt && rt==held regWAddr).
- Incoming reads rs: every opcode except J and JAL.
- Incoming reads rt: R-type, BEQ, BNE, SW.
- stall is 0 when inValid=0.
- While stall is asserted and outReady=1, the held LW drains and outValid=0 next cycle (one bubble). The next cycle re-evaluates stall, which is now 0, and the instruction is accepted.

Flush:
- Priority order is reset > flush > handshake.
- flush=1: outValid=0 next cycle, inReady=0, and no accept that cycle.

Decode (opcode hex / funct hex), fields given as op, aluB, regWe, regDIn, pcSrc, dmWe, bne, regWAddr:
- LW 23: ADD, IMM, 1, DM, INC4, dmWe 0, bne 0, rt.
- SW 2b: ADD, IMM, regWe 0, dmWe 1.
- J 02: pcSrc J, no writes.
- JAL 03: pcSrc J, regWe 1, LINK, regWAddr=LINK_REG.
- BEQ 04 / BNE 05: SUB, REG, pcSrc BR; bneCtrl 0 for BEQ, 1 for BNE.
- ADDI 08: ADD, IMM, 1, rt.
- XORI 0e: XOR, IMM, 1, rt.
- SLTI 0a (EXT): SLT, IMM, 1, rt.
- ANDI 0c (EXT): AND, IMM, 1, rt.
- ORI 0d (EXT): OR, IMM, 1, rt.
- R-type 00: REG, regWAddr=rd.
  - JR 08: pcSrc JR, regWe 0.
  - ADD 20: ADD, regWe 1.
  - SUB 22: SUB, regWe 1.
  - SLT 2a: SLT, regWe 1.
  - AND 24 (EXT): AND, regWe 1.
  - OR 25 (EXT): OR, regWe 1.
  - XOR 26 (EXT): XOR, regWe 1.
  - NOR 27 (EXT): NOR, regWe 1.
  - JALR 09 (EXT): pcSrc JR, LINK, regWe 1.
- Unlisted fields are 0.

Illegal instructions:
- Applies to unknown opcode/funct, and EXT encodings when ENABLE_EXT=0.
- Outputs: illegal=1, all strobes 0, pcSrc INC4, op ADD. The bundle is still passed with outValid.

Immediate:
- imm = sign-extension of instr[15:0] to XLEN.
- Exception: ANDI/ORI/XORI zero-extend when ZERO_EXT_LOGIC=1.

Register-0 writes:
- regWe is forced 0 whenever the final regWAddr==0.

Test Plan:
- Reset with inValid=1 → outValid=0, inReady=0 during reset. First cycle after reset: ADDI $t0,$zero,-1 (0x2008ffff) is accepted. Next cycle: op=0, imm=0xffffffff, regWAddr=8, regWe=1.
- XORI 0x3908ffff, ZERO_EXT_LOGIC=1 → imm=0x0000ffff. With ZERO_EXT_LOGIC=0 → imm=0xffffffff.
- LW $t0,0($sp) then ADD $t1,$t0,$t0, outReady=1 → stall=1 for one cycle, one bubble (outValid=0), ADD valid two cycles after the LW bundle. ADD $t1,$t1,$t1 after LW $t0 → no stall.
- outReady=0 for 3 cycles with a valid bundle → bundle stable, inReady=0. Then outReady=1 with inValid=1 → back-to-back transfer, no bubble.
- flush asserted with a valid held BEQ and inValid=1 → outValid=0 next cycle, input not accepted. Input is accepted the following cycle.
- ENABLE_EXT=0: AND (0x01095024) → illegal=1, regWe=0. ENABLE_EXT=1 → op=4, regWAddr=10. ADD $zero,.. → regWe=0. JAL → regWAddr=31, regDInCtrl=2.
